// File: rtl/player_vertical_motion_pkg.sv
// ============================================================================
// Module   : player_vertical_motion_pkg
// Brief    : Shared vertical-physics types and the screen constants that the
//            collision stage uses.
// Revision : 1.0
// ============================================================================
`default_nettype none

package player_vertical_motion_pkg;

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_AIRBORNE = 2'd1,
        ST_RESPAWN  = 2'd2
    } state_e;

    typedef logic signed [10:0] pos_t;
    typedef logic signed [5:0]  vel_t;

    // These must match the main-platform collision stage.
    localparam int KILL_Y     = 480;
    localparam int PLATFORM_Y = 380;

endpackage

`default_nettype wire

// File: rtl/player_vertical_motion.sv
// ============================================================================
// Module   : player_vertical_motion
// Brief    : Per-player vertical physics: gravity, landing, double jump and
//            respawn, committed once per frame_tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module player_vertical_motion
    import player_vertical_motion_pkg::*;
#(
    parameter int HEIGHT         = 16,
    parameter int SPAWN_Y        = 100,
    parameter int GRAVITY        = 1,
    parameter int MAX_FALL       = 8,
    parameter int JUMP_VEL       = -10,
    parameter int MAX_JUMPS      = 2,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               jump_btn,
    input  logic               touching_platform,
    output logic signed [10:0] y_pos,
    output logic signed [10:0] next_y,
    output logic signed [5:0]  vel_y,
    output logic               grounded,
    output logic               respawning
);

    localparam int CNT_W   = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
    localparam int JUMPS_W = $clog2(MAX_JUMPS + 1);

    localparam pos_t                C_LAND_Y    = pos_t'(PLATFORM_Y - 2 * HEIGHT);
    localparam pos_t                C_SPAWN_Y   = pos_t'(SPAWN_Y);
    localparam pos_t                C_KILL_Y    = pos_t'(KILL_Y);
    localparam vel_t                C_JUMP_VEL  = vel_t'(JUMP_VEL);
    localparam logic signed [6:0]   C_GRAVITY7  = 7'(GRAVITY);
    localparam logic signed [6:0]   C_MAXFALL7  = 7'(MAX_FALL);
    localparam logic [JUMPS_W-1:0]  C_MAX_JUMPS = JUMPS_W'(MAX_JUMPS);
    localparam logic [JUMPS_W-1:0]  C_AIR_JUMPS = JUMPS_W'(MAX_JUMPS - 1);
    localparam logic [JUMPS_W-1:0]  C_ONE_JUMP  = JUMPS_W'(1);
    localparam logic [CNT_W-1:0]    C_CNT_LAST  = CNT_W'(RESPAWN_FRAMES - 1);
    localparam logic [CNT_W-1:0]    C_CNT_ONE   = CNT_W'(1);

    state_e               state_q;
    pos_t                 y_q;
    vel_t                 vel_q;
    logic [JUMPS_W-1:0]   jumps_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 jump_prev_q;
    logic                 jump_req_q;

    logic                 jump_rise_w;
    logic                 jump_req_w;
    logic signed [11:0]   addend_w;
    logic signed [11:0]   sum_w;
    pos_t                 next_y_w;
    logic signed [6:0]    vel_grav_w;
    vel_t                 vel_fall_d;

    // An edge arriving in the tick cycle itself still counts for that tick.
    assign jump_rise_w = jump_btn & ~jump_prev_q;
    assign jump_req_w  = jump_req_q | jump_rise_w;

    always_comb begin
        addend_w = 12'sd0;
        case (state_q)
            ST_GROUNDED: addend_w = 12'sd1;
            ST_AIRBORNE: addend_w = {{6{vel_q[5]}}, vel_q};
            default:     addend_w = 12'sd0;
        endcase
    end

    assign sum_w = {y_q[10], y_q} + addend_w;

    always_comb begin
        next_y_w = sum_w[10:0];
        if (sum_w[11] != sum_w[10]) begin
            next_y_w = sum_w[11] ? 11'sh400 : 11'sh3FF;
        end
    end

    assign vel_grav_w = {vel_q[5], vel_q} + C_GRAVITY7;
    assign vel_fall_d = (vel_grav_w > C_MAXFALL7) ? vel_t'(MAX_FALL) : vel_grav_w[5:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_AIRBORNE;
            y_q         <= C_SPAWN_Y;
            vel_q       <= '0;
            jumps_q     <= C_MAX_JUMPS;
            cnt_q       <= '0;
            jump_prev_q <= 1'b0;
            jump_req_q  <= 1'b0;
        end else begin
            jump_prev_q <= jump_btn;
            jump_req_q  <= frame_tick ? 1'b0 : jump_req_w;
            if (frame_tick) begin
                case (state_q)
                    ST_GROUNDED: begin
                        if (jump_req_w) begin
                            vel_q   <= C_JUMP_VEL;
                            jumps_q <= C_AIR_JUMPS;
                            state_q <= ST_AIRBORNE;
                        end else if (!touching_platform) begin
                            vel_q   <= '0;
                            jumps_q <= C_AIR_JUMPS;
                            state_q <= ST_AIRBORNE;
                        end
                    end
                    ST_AIRBORNE: begin
                        if (y_q > C_KILL_Y) begin
                            state_q <= ST_RESPAWN;
                            cnt_q   <= '0;
                            vel_q   <= '0;
                        end else if (touching_platform && !vel_q[5]) begin
                            y_q     <= C_LAND_Y;
                            vel_q   <= '0;
                            jumps_q <= C_MAX_JUMPS;
                            state_q <= ST_GROUNDED;
                        end else if (jump_req_w && (jumps_q != '0)) begin
                            y_q     <= next_y_w;
                            vel_q   <= C_JUMP_VEL;
                            jumps_q <= jumps_q - C_ONE_JUMP;
                        end else begin
                            y_q     <= next_y_w;
                            vel_q   <= vel_fall_d;
                        end
                    end
                    ST_RESPAWN: begin
                        if (cnt_q == C_CNT_LAST) begin
                            y_q     <= C_SPAWN_Y;
                            vel_q   <= '0;
                            jumps_q <= C_MAX_JUMPS;
                            state_q <= ST_AIRBORNE;
                        end else begin
                            cnt_q   <= cnt_q + C_CNT_ONE;
                        end
                    end
                    default: state_q <= ST_AIRBORNE;
                endcase
            end
        end
    end

    assign y_pos      = y_q;
    assign next_y     = next_y_w;
    assign vel_y      = vel_q;
    assign grounded   = (state_q == ST_GROUNDED);
    assign respawning = (state_q == ST_RESPAWN);

endmodule

`default_nettype wire

// File: tb/tb_player_vertical_motion.sv
// ============================================================================
// Module   : tb_player_vertical_motion
// Brief    : Directed, table-driven bench for player_vertical_motion.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_player_vertical_motion;

    logic               clk;
    logic               rst_n;
    logic               frame_tick;
    logic               jump_btn;
    logic               touching_platform;
    logic signed [10:0] y_pos;
    logic signed [10:0] next_y;
    logic signed [5:0]  vel_y;
    logic               grounded;
    logic               respawning;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic tick;
        logic jump;
        logic touch;
        int   y;
        int   vel;
        logic g;
        logic r;
    } vec_t;

    vec_t vecs [17];

    player_vertical_motion dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .frame_tick        (frame_tick),
        .jump_btn          (jump_btn),
        .touching_platform (touching_platform),
        .y_pos             (y_pos),
        .next_y            (next_y),
        .vel_y             (vel_y),
        .grounded          (grounded),
        .respawning        (respawning)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int ey, input int ev,
                       input logic eg, input logic er);
        int en;
        en = eg ? ey + 1 : (er ? ey : ey + ev);
        checks++;
        if ((int'(y_pos) !== ey) || (int'(vel_y) !== ev) || (int'(next_y) !== en) ||
            (grounded !== eg) || (respawning !== er)) begin
            errors++;
            $display("FAIL %s: got y=%0d vel=%0d next=%0d g=%b r=%b, expected y=%0d vel=%0d next=%0d g=%b r=%b",
                     name, y_pos, vel_y, next_y, grounded, respawning, ey, ev, en, eg, er);
        end
    endtask

    task automatic cyc(input logic t, input logic j, input logic c);
        frame_tick        = t;
        jump_btn          = j;
        touching_platform = c;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic do_tick(input logic j, input logic c);
        cyc(1'b1, j, c);
    endtask

    initial begin
        int guard;

        //               tick  jump  touch  y    vel  g     r
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 100,   0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 100,   1, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 100,   1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 101,   2, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 103,   3, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 106,   4, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 110,   5, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 115,   6, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 121,   7, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 128,   8, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 136,   8, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 144,   8, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 144,   8, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 152, -10, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 142,  -9, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 133,  -8, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 125,  -7, 1'b0, 1'b0};

        rst_n             = 1'b0;
        frame_tick        = 1'b0;
        jump_btn          = 1'b0;
        touching_platform = 1'b0;
        #12;
        chk("reset", 100, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            cyc(vecs[i].tick, vecs[i].jump, vecs[i].touch);
            chk($sformatf("vec%0d", i), vecs[i].y, vecs[i].vel, vecs[i].g, vecs[i].r);
        end

        guard = 0;
        while (y_pos < 330 && guard < 100) begin
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("fall_to_333", 333, 8, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("land", 348, 0, 1'b1, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("ground_hold", 348, 0, 1'b1, 1'b0);

        cyc(1'b0, 1'b1, 1'b1);
        chk("edge_no_tick", 348, 0, 1'b1, 1'b0);
        do_tick(1'b1, 1'b1);
        chk("ground_jump", 348, -10, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("rise1", 338, -9, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("air_jump", 329, -10, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("rise2", 319, -9, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("third_jump_ignored", 310, -8, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("rise3", 302, -7, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) do_tick(1'b0, 1'b0);
        chk("apex", 274, 0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("land2", 348, 0, 1'b1, 1'b0);

        for (int i = 0; i < 10; i++) do_tick(1'b1, 1'b0);
        chk("held_one_jump", 294, -1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("held_apex", 293, 0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1);
        chk("land3", 348, 0, 1'b1, 1'b0);

        do_tick(1'b0, 1'b0);
        chk("walk_off", 348, 0, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("walk_off_air_jump", 348, -10, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("walk_off_rise", 338, -9, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("walk_off_no_more", 329, -8, 1'b0, 1'b0);

        guard = 0;
        while (y_pos <= 480 && guard < 100) begin
            do_tick(1'b0, 1'b0);
            guard++;
        end
        chk("fall_to_481", 481, 8, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("enter_respawn", 481, 0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) begin
            do_tick(logic'(i % 2), 1'b0);
            chk($sformatf("respawn_hold%0d", i), 481, 0, 1'b0, 1'b1);
        end
        do_tick(1'b1, 1'b0);
        chk("respawn_exit", 100, 0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("respawn_jump_ignored", 100, 1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("post_respawn_jump1", 101, -10, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0);
        chk("post_respawn_rise", 91, -9, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0);
        chk("post_respawn_jump2", 82, -10, 1'b0, 1'b0);

        jump_btn = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_jump", 100, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        do_tick(1'b0, 1'b0);
        chk("after_reset_tick", 100, 1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/player_vertical_motion.md
Name: player_vertical_motion

Overview:
- Per-player vertical physics stage, once per frame.
- Holds y_pos and vertical velocity and drives next_y into the main-platform collision check.
- Takes that check's touching_platform result back in the same cycle, then commits landing, falling, jumping or respawn on each frame_tick.
- Sits between the input/controller logic and the sprite renderer.

Parameters:
- HEIGHT, 16, sprite half-height in pixels; the character bottom is y_pos + HEIGHT*2.
- PLATFORM_Y, 380, platform top row; landing snaps y_pos to PLATFORM_Y - HEIGHT*2.
- SPAWN_Y, 100, y_pos loaded at reset and after respawn.
- GRAVITY, 1, velocity increment per frame while airborne.
- MAX_FALL, 8, terminal downward velocity (positive is down).
- JUMP_VEL, -10, velocity loaded on a jump.
- MAX_JUMPS, 2, jumps available per landing (ground jump plus one air jump).
- KILL_Y, 480, y_pos strictly greater than this triggers respawn.
- RESPAWN_FRAMES, 60, frames spent in RESPAWN before the player reappears.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- jump_btn, input, 1, level from the debounced controller.
- touching_platform, input, 1, combinational result from the collision stage for (x_pos, y_pos, next_y).
- y_pos, output, 11 signed, current top-of-sprite row (registered).
- next_y, output, 11 signed, candidate y for this frame (combinational).
- vel_y, output, 6 signed, current vertical velocity (registered).
- grounded, output, 1, high in GROUNDED state.
- respawning, output, 1, high in RESPAWN state; the renderer hides the sprite.

Behaviour:
Clock and reset:
- Single clock domain: clk.
- Reset rst_n is asynchronous and active-low.
- Reset values: state=AIRBORNE, y_pos=SPAWN_Y, vel_y=0, jumps_left=MAX_JUMPS, jump_req=0, respawn counter=0. Hence grounded=0 and respawning=0.

Jump request latch:
- A rising edge of jump_btn (registered previous value) sets jump_req.
- jump_req is cleared on any frame_tick.
- An edge coincident with frame_tick is honoured on that tick.
- A held button never re-triggers.

next_y (combinational; the sum is computed at 12 bits and saturated to the 11-bit signed range):
- GROUNDED: y_pos + 1 (one-pixel ground probe).
- AIRBORNE: y_pos + vel_y.
- RESPAWN: y_pos.

State updates happen only on frame_tick; all registers hold otherwise. Landing and ground-loss decisions use touching_platform sampled in the tick cycle.

GROUNDED on tick:
- If jump_req: vel_y<=JUMP_VEL, jumps_left<=MAX_JUMPS-1, go to AIRBORNE, y_pos unchanged.
- Else if !touching_platform (walked off the edge): vel_y<=0, jumps_left<=MAX_JUMPS-1, go to AIRBORNE.
- Else: hold.

AIRBORNE on tick, priority order:
1. y_pos > KILL_Y: go to RESPAWN, counter<=0, vel_y<=0.
2. touching_platform && vel_y>=0: y_pos<=PLATFORM_Y-HEIGHT*2, vel_y<=0, jumps_left<=MAX_JUMPS, go to GROUNDED.
3. jump_req && jumps_left>0: y_pos<=next_y, vel_y<=JUMP_VEL, jumps_left decremented.
4. Otherwise: y_pos<=next_y, vel_y<=min(vel_y+GRAVITY, MAX_FALL).
- A jump with jumps_left==0 is ignored; the request is still cleared.

RESPAWN on tick:
- Counter increments each tick.
- When the counter reaches RESPAWN_FRAMES-1: y_pos<=SPAWN_Y, vel_y<=0, jumps_left<=MAX_JUMPS, go to AIRBORNE.
- Jump requests are ignored in RESPAWN.

Other rules:
- Velocity never exceeds MAX_FALL.
- Upward velocity is only ever JUMP_VEL or the result of adding gravity to it.
- Reset mid-jump or mid-respawn returns immediately to the reset values.

Decomposition:
- Shared physics package holds:
  - the state enum (GROUNDED, AIRBORNE, RESPAWN);
  - the 11-bit signed position typedef and 6-bit signed velocity typedef;
  - the screen constants KILL_Y and PLATFORM_Y, which must be the same values the collision stage uses.
- No sub-module. The edge detector and saturating adder are small enough to stay inline.

Test Plan:
- Reset with rst_n=0 mid-frame -> immediately y_pos=100, vel_y=0, grounded=0, respawning=0.
- Free fall with the collision stub returning 0 -> vel_y sequence 0,1,2,...,8,8 over ticks; y_pos=100,100,101,103,106,...; next_y=y_pos+vel_y each cycle.
- Landing: at y_pos=340, vel_y=8 the stub asserts touching_platform -> next tick y_pos=348, vel_y=0, grounded=1. A tick with vel_y<0 and touching_platform=1 -> no landing.
- Jumps: jump_btn rises while grounded at 348 -> vel_y=-10, grounded=0. A second edge mid-air -> vel_y=-10 again. A third edge -> ignored, gravity continues. A held button across 10 ticks -> exactly one jump.
- Edge walk-off: grounded, stub drops touching_platform -> next tick grounded=0, vel_y=0, and one air jump is still available.
- Respawn: fall until y_pos=481 -> respawning=1 for 60 ticks with y_pos frozen, then y_pos=100, respawning=0, AIRBORNE. Jumps during RESPAWN are ignored.
